button_conditioner: RTL
=======================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter N_BTN, default 3; number of independent push-button channels (for example Run, ClearA_LoadB, spare).
REQ-002 Parameter DB_CYCLES, default 500000; debounce stability window in Clk cycles (10 ms at 50 MHz); legal range 1..2^20-1.
REQ-003 Clk  input  1  system clock; all state updates on the rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset, sampled on the rising edge of Clk.
REQ-005 btn_n  input  N_BTN  raw, asynchronous, bouncing keys; active-low (0 = pressed).
REQ-006 level  output  N_BTN  debounced pressed state, active-high; this drives the multiplier controller's Run input.
REQ-007 press  output  N_BTN  one-cycle pulse on a debounced press.
REQ-008 release  output  N_BTN  one-cycle pulse on a debounced release.

Function
REQ-009 Each btn_n bit SHALL pass through a two-flop synchronizer before any other use; the synchronized value is inverted to form pressed_s.
REQ-010 Each channel SHALL run an independent FSM with states S_OFF, S_ON_PEND, S_ON and S_OFF_PEND, plus its own ceil(log2(DB_CYCLES+1))-bit counter.
REQ-011 S_OFF: if pressed_s=1, go to S_ON_PEND and clear the counter; otherwise stay.
REQ-012 S_ON_PEND: if pressed_s=0, return to S_OFF and clear the counter.
REQ-013 S_ON_PEND: if pressed_s=1 and counter=DB_CYCLES-1, go to S_ON.
REQ-014 S_ON_PEND: otherwise, increment the counter.
REQ-015 S_ON, S_OFF_PEND: same rules as S_OFF and S_ON_PEND with pressed_s inverted; a completed window goes to S_OFF.
REQ-016 level SHALL be 1 exactly when the FSM is in S_ON or S_OFF_PEND.
REQ-017 level, press and release SHALL be registered outputs, updated on the same edge as the state transition.
REQ-018 press SHALL be 1 for exactly the one cycle following the S_ON_PEND->S_ON edge.
REQ-019 release SHALL be 1 for exactly the one cycle following the S_OFF_PEND->S_OFF edge.
REQ-020 Latency: with btn_n held low from edge k onward, level and press SHALL rise after edge k+DB_CYCLES+3; release latency is symmetric.
REQ-021 Any bounce shorter than DB_CYCLES consecutive synchronized samples SHALL produce no change on level, press or release.
REQ-022 Each bounce SHALL restart the window from zero; the window never accumulates across bounces.
REQ-023 The counter SHALL never wrap; it holds at most DB_CYCLES-1.
REQ-024 press and release SHALL never be 1 on the same channel in the same cycle.
REQ-025 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each behave as if alone.
REQ-026 With DB_CYCLES=1, a pending state SHALL resolve on the first edge spent in it.

Reset
REQ-027 Reset=1 SHALL set all synchronizer flops to 1 (released), all FSMs to S_OFF, all counters to 0, and level, press and release to 0.
REQ-028 Reset asserted mid-debounce or mid-pulse SHALL abort the operation; no press or release SHALL be emitted for the aborted window.
REQ-029 A key held down through Reset deassertion SHALL be treated as a new press: press is emitted DB_CYCLES+3 edges after the first edge with Reset=0.

Structure
REQ-030 A shared package button_pkg SHALL hold the channel-state enum (2-bit) and the DB_CYCLES default constant.
REQ-031 The single-channel synchronizer, FSM and counter SHALL live in a sub-module debounce_channel.
REQ-032 button_conditioner SHALL instantiate debounce_channel N_BTN times via generate and contain no other logic.

Verification (DB_CYCLES=4, N_BTN=3)
REQ-033 Clean press: btn_n[0] 1->0 at edge 10 and held -> level[0]=1 and press[0]=1 after edge 17; press[0]=0 after edge 18.
REQ-034 Bounce rejection: btn_n[1] low for 3 cycles, high for 2, then low and held -> exactly one press[1] pulse, 7 edges after the final falling sample; level[1] stays 0 before that.
REQ-035 Release: from S_ON, btn_n[0] returns high at edge 40 -> release[0] pulse and level[0]=0 after edge 47; no press pulse.
REQ-036 Simultaneous events: btn_n=3'b000 at edge 5 -> press=3'b111 for one cycle after edge 12; level=3'b111 thereafter.
REQ-037 Reset mid-operation: Reset=1 at edge 14 while channel 0 is in S_ON_PEND with btn_n[0]=0 held -> all outputs 0 during Reset; Reset=0 from edge 16 -> press[0] after edge 23.
REQ-038 All scenarios: assertion checks press&release==0 and that each pulse lasts exactly one cycle.

Source files
------------

// File: rtl/button_pkg.sv
// button_pkg
//   Shared definitions for the push-button conditioner.
//   - chan_state_t      : per-channel debounce FSM state (2-bit)
//   - DB_CYCLES_DEFAULT : default stability window (10 ms at 50 MHz)
//   - DB_CYCLES_MAX     : largest supported window
//   - count_width()     : bits needed for a counter that can reach DB_CYCLES
package button_pkg;

    typedef enum logic [1:0] {
        S_OFF      = 2'd0,
        S_ON_PEND  = 2'd1,
        S_ON       = 2'd2,
        S_OFF_PEND = 2'd3
    } chan_state_t;

    localparam int DB_CYCLES_DEFAULT = 500000;
    localparam int DB_CYCLES_MAX     = (1 << 20) - 1;

    // ceil(log2(cycles+1)): the window counter never has to hold more than
    // cycles-1, but this width keeps DB_CYCLES=1 at a legal 1-bit counter.
    function automatic int count_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel
//   One push-button channel: two-flop synchronizer, four-state debounce FSM
//   and its stability-window counter. The key must read the same level for
//   DB_CYCLES consecutive synchronized samples before the debounced state
//   changes; any disagreeing sample restarts the window from zero.
//
// Ports
//   Clk           in   system clock, rising edge
//   Reset         in   synchronous, active-high
//   btn_n         in   raw asynchronous key, active-low (0 = pressed)
//   level         out  debounced pressed state, active-high (registered)
//   press         out  one-cycle pulse on a debounced press (registered)
//   release_pulse out  one-cycle pulse on a debounced release (registered);
//                      named this way because "release" is a reserved word
module debounce_channel
    import button_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT   // legal range 1..2^20-1
) (
    input  logic Clk,
    input  logic Reset,
    input  logic btn_n,
    output logic level,
    output logic press,
    output logic release_pulse
);

    localparam int            CW   = count_width(DB_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          pressed_s;
    chan_state_t   state;
    chan_state_t   next_state;
    logic [CW-1:0] count;
    logic [CW-1:0] next_count;
    logic          next_level;
    logic          next_press;
    logic          next_release;

    // Synchronizer resets to 1 so a key held through reset is seen as a
    // fresh press once reset is released.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], btn_n};
        end
    end

    assign pressed_s = ~sync_q[1];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= S_OFF;
            count         <= '0;
            level         <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= next_state;
            count         <= next_count;
            level         <= next_level;
            press         <= next_press;
            release_pulse <= next_release;
        end
    end

    // The pending states count agreeing samples; reaching LAST while the
    // input still agrees commits the change. The counter is cleared on every
    // state change, so it never exceeds LAST and never wraps.
    always_comb begin
        next_state   = state;
        next_count   = count;
        next_press   = 1'b0;
        next_release = 1'b0;

        case (state)
            S_OFF: begin
                if (pressed_s) begin
                    next_state = S_ON_PEND;
                    next_count = '0;
                end
            end
            S_ON_PEND: begin
                if (!pressed_s) begin
                    next_state = S_OFF;
                    next_count = '0;
                end else if (count == LAST) begin
                    next_state = S_ON;
                    next_count = '0;
                    next_press = 1'b1;
                end else begin
                    next_count = count + CW'(1);
                end
            end
            S_ON: begin
                if (!pressed_s) begin
                    next_state = S_OFF_PEND;
                    next_count = '0;
                end
            end
            S_OFF_PEND: begin
                if (pressed_s) begin
                    next_state = S_ON;
                    next_count = '0;
                end else if (count == LAST) begin
                    next_state   = S_OFF;
                    next_count   = '0;
                    next_release = 1'b1;
                end else begin
                    next_count = count + CW'(1);
                end
            end
            default: begin
                next_state = S_OFF;
                next_count = '0;
            end
        endcase

        next_level = (next_state == S_ON) || (next_state == S_OFF_PEND);
    end

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner
//   N_BTN independent debounced push-button channels. Each channel is a
//   debounce_channel instance; this level only fans the buses out.
//
// Ports
//   Clk           in   system clock, rising edge
//   Reset         in   synchronous, active-high
//   btn_n         in   [N_BTN] raw keys, active-low
//   level         out  [N_BTN] debounced pressed state (drives controller Run)
//   press         out  [N_BTN] one-cycle pulse per debounced press
//   release_pulse out  [N_BTN] one-cycle pulse per debounced release
module button_conditioner
    import button_pkg::*;
#(
    parameter int N_BTN     = 3,
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [N_BTN-1:0] btn_n,
    output logic [N_BTN-1:0] level,
    output logic [N_BTN-1:0] press,
    output logic [N_BTN-1:0] release_pulse
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        debounce_channel #(
            .DB_CYCLES(DB_CYCLES)
        ) u_chan (
            .Clk          (Clk),
            .Reset        (Reset),
            .btn_n        (btn_n[i]),
            .level        (level[i]),
            .press        (press[i]),
            .release_pulse(release_pulse[i])
        );
    end

endmodule
